// File: rtl/readout_rx_state_decision_output_multi.sv
// Multi-channel readout state-decision output stage: per-channel registered decisions plus
// mask-selected round collection with timeout. Optional excited counters: READOUT_RX_EXCITED_COUNT_EN.
module readout_rx_state_decision_output_multi #(
  parameter int NUM_QUBIT      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic [NUM_QUBIT-1:0] meas_mask_in,
  input  logic [NUM_QUBIT-1:0] finish_count_in,
  input  logic [NUM_QUBIT-1:0] meas_result_condition,
  output logic [NUM_QUBIT-1:0] ch_valid_out,
  output logic [NUM_QUBIT-1:0] ch_result_out,
  output logic                 valid_meas_result_out,
  output logic [NUM_QUBIT-1:0] meas_result_out,
  output logic                 timeout_out,
  output logic [NUM_QUBIT-1:0] missing_out,
  output logic                 busy_out
`ifdef READOUT_RX_EXCITED_COUNT_EN
  ,
  input  logic                           cnt_clear_in,
  output logic [NUM_QUBIT*CNT_WIDTH-1:0] excited_cnt_out
`endif
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t               state, state_nxt;
  logic [NUM_QUBIT-1:0] mask_r, done_r, res_r;
  logic [NUM_QUBIT-1:0] mask_nxt, done_nxt, res_nxt;
  logic [NUM_QUBIT-1:0] first_hit, done_upd, res_upd, hit;
  logic [CW-1:0]        cnt_r, cnt_nxt;
  logic                 valid_nxt, timeout_nxt;
  logic [NUM_QUBIT-1:0] result_nxt, missing_nxt;

  assign hit      = finish_count_in & meas_result_condition;
  assign busy_out = (state == COLLECT);

  always_comb begin
    // Only the first finish of a masked channel contributes, so OR-ing into a cleared res_r keeps first-wins.
    first_hit   = finish_count_in & mask_r & ~done_r;
    done_upd    = done_r | first_hit;
    res_upd     = res_r | (first_hit & meas_result_condition);
    state_nxt   = state;
    mask_nxt    = mask_r;
    done_nxt    = done_r;
    res_nxt     = res_r;
    cnt_nxt     = cnt_r;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    result_nxt  = '0;
    missing_nxt = '0;
    case (state)
      IDLE: begin
        if (start_in) begin
          mask_nxt  = meas_mask_in;
          done_nxt  = '0;
          res_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (start_in) begin
          mask_nxt = meas_mask_in;
          done_nxt = '0;
          res_nxt  = '0;
          cnt_nxt  = '0;
        end else begin
          done_nxt = done_upd;
          res_nxt  = res_upd;
          cnt_nxt  = cnt_r + CW'(1);
          if (done_upd == mask_r) begin
            valid_nxt  = 1'b1;
            result_nxt = res_upd;
            state_nxt  = IDLE;
          end else if (TO_EN && (cnt_r == TO_LAST)) begin
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b1;
            missing_nxt = mask_r & ~done_upd;
            result_nxt  = res_upd;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      mask_r                <= '0;
      done_r                <= '0;
      res_r                 <= '0;
      cnt_r                 <= '0;
      ch_valid_out          <= '0;
      ch_result_out         <= '0;
      valid_meas_result_out <= 1'b0;
      meas_result_out       <= '0;
      timeout_out           <= 1'b0;
      missing_out           <= '0;
    end else begin
      state                 <= state_nxt;
      mask_r                <= mask_nxt;
      done_r                <= done_nxt;
      res_r                 <= res_nxt;
      cnt_r                 <= cnt_nxt;
      ch_valid_out          <= finish_count_in;
      ch_result_out         <= hit;
      valid_meas_result_out <= valid_nxt;
      meas_result_out       <= result_nxt;
      timeout_out           <= timeout_nxt;
      missing_out           <= missing_nxt;
    end
  end

`ifdef READOUT_RX_EXCITED_COUNT_EN
  logic [NUM_QUBIT*CNT_WIDTH-1:0] exc_cnt_r;

  assign excited_cnt_out = exc_cnt_r;

  // Counts are mask-independent and saturate; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cnt_r <= '0;
    end else if (cnt_clear_in) begin
      exc_cnt_r <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_QUBIT; i++) begin
        if (hit[i] && (exc_cnt_r[i*CNT_WIDTH +: CNT_WIDTH] != '1))
          exc_cnt_r[i*CNT_WIDTH +: CNT_WIDTH] <= exc_cnt_r[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_readout_rx_state_decision_output_multi.sv
// Bench for readout_rx_state_decision_output_multi: per-channel vector table plus a round scoreboard.
module tb_readout_rx_state_decision_output_multi;

  localparam int NQ = 8;
  localparam int TO = 16;
  localparam int CWB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [NQ-1:0] meas_mask_in, finish_count_in, meas_result_condition;
  logic [NQ-1:0] ch_valid_out, ch_result_out, meas_result_out, missing_out;
  logic          valid_meas_result_out, timeout_out, busy_out;
`ifdef READOUT_RX_EXCITED_COUNT_EN
  logic              cnt_clear_in;
  logic [NQ*CWB-1:0] excited_cnt_out;
`endif

  readout_rx_state_decision_output_multi #(
    .NUM_QUBIT(NQ),
    .TIMEOUT_CYCLES(TO)
`ifdef READOUT_RX_EXCITED_COUNT_EN
    , .CNT_WIDTH(CWB)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .meas_mask_in(meas_mask_in),
    .finish_count_in(finish_count_in),
    .meas_result_condition(meas_result_condition),
    .ch_valid_out(ch_valid_out),
    .ch_result_out(ch_result_out),
    .valid_meas_result_out(valid_meas_result_out),
    .meas_result_out(meas_result_out),
    .timeout_out(timeout_out),
    .missing_out(missing_out),
    .busy_out(busy_out)
`ifdef READOUT_RX_EXCITED_COUNT_EN
    , .cnt_clear_in(cnt_clear_in),
    .excited_cnt_out(excited_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NQ-1:0] res;
    logic          tmo;
    logic [NQ-1:0] miss;
    int            at;
  } round_t;

  round_t sb[$];
  round_t e;

  typedef struct {
    logic [NQ-1:0] fin;
    logic [NQ-1:0] cond;
    logic [NQ-1:0] exp_valid;
    logic [NQ-1:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_round(input logic [NQ-1:0] res, input logic tmo,
                            input logic [NQ-1:0] miss, input int at);
    round_t r;
    r.res  = res;
    r.tmo  = tmo;
    r.miss = miss;
    r.at   = at;
    sb.push_back(r);
  endtask

  // Round monitor: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_meas_result_out) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got valid=1 result=0x%0h at cycle %0d, expected no round pending",
                   meas_result_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("round_result", 64'(meas_result_out), 64'(e.res));
          chk("round_timeout", 64'(timeout_out), 64'(e.tmo));
          chk("round_missing", 64'(missing_out), 64'(e.miss));
          chk("round_cycle", 64'(cyc), 64'(e.at));
        end
      end else begin
        chk("idle_outputs_zero", 64'({meas_result_out, missing_out, timeout_out}), 64'd0);
      end
    end
  end

`ifdef READOUT_RX_EXCITED_COUNT_EN
  int mcnt;
`endif

  initial begin
    rst = 1'b1;
    start_in = 1'b0;
    meas_mask_in = '0;
    finish_count_in = '0;
    meas_result_condition = '0;
`ifdef READOUT_RX_EXCITED_COUNT_EN
    cnt_clear_in = 1'b0;
`endif

    vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'hA5, 8'h3C, 8'hA5, 8'h24};
    vecs[4] = '{8'h0F, 8'hF0, 8'h0F, 8'h00};
    vecs[5] = '{8'h81, 8'h81, 8'h81, 8'h81};
    vecs[6] = '{8'h5A, 8'hFF, 8'h5A, 8'h5A};

    step(3);
    chk("reset_outputs", 64'({ch_valid_out, ch_result_out, meas_result_out, missing_out,
                              valid_meas_result_out, timeout_out, busy_out}), 64'd0);
    rst = 1'b0;
    step(2);

    // Per-channel path, 1-cycle latency, in IDLE
    for (int i = 0; i < 7; i++) begin
      finish_count_in = vecs[i].fin;
      meas_result_condition = vecs[i].cond;
      step(1);
      chk("ch_valid_vec", 64'(ch_valid_out), 64'(vecs[i].exp_valid));
      chk("ch_result_vec", 64'(ch_result_out), 64'(vecs[i].exp_res));
    end
    finish_count_in = '0;
    meas_result_condition = '0;
    step(2);

    // Full round: finishes at cycles 2,5,5,9 -> valid at cycle 10
    start_in = 1'b1;
    meas_mask_in = 8'h0F;
    push_round(8'h0D, 1'b0, 8'h00, cyc + 10);
    step(1);
    start_in = 1'b0;
    chk("busy_collect", 64'(busy_out), 64'd1);
    step(1);
    finish_count_in = 8'h01; meas_result_condition = 8'h01;
    step(1);
    chk("full_ch_valid0", 64'(ch_valid_out), 64'h01);
    chk("full_ch_result0", 64'(ch_result_out), 64'h01);
    finish_count_in = '0; meas_result_condition = '0;
    step(2);
    finish_count_in = 8'h06; meas_result_condition = 8'h04;
    step(1);
    chk("full_ch_valid12", 64'(ch_valid_out), 64'h06);
    chk("full_ch_result12", 64'(ch_result_out), 64'h04);
    finish_count_in = '0; meas_result_condition = '0;
    step(3);
    finish_count_in = 8'h08; meas_result_condition = 8'h08;
    step(1);
    finish_count_in = '0; meas_result_condition = '0;
    step(3);
    chk("busy_after_round", 64'(busy_out), 64'd0);

    // Duplicates and unmasked channel
    start_in = 1'b1;
    meas_mask_in = 8'h03;
    push_round(8'h01, 1'b0, 8'h00, cyc + 5);
    step(1);
    start_in = 1'b0;
    finish_count_in = 8'h21; meas_result_condition = 8'h21;
    step(1);
    chk("unmasked_ch5_result", 64'(ch_result_out[5]), 64'd1);
    finish_count_in = 8'h01; meas_result_condition = 8'h00;
    step(2);
    finish_count_in = 8'h02; meas_result_condition = 8'h00;
    step(1);
    finish_count_in = '0;
    step(4);

    // Timeout: only ch0 finishes -> valid on 16th COLLECT edge
    start_in = 1'b1;
    meas_mask_in = 8'h07;
    push_round(8'h01, 1'b1, 8'h06, cyc + TO + 1);
    step(1);
    start_in = 1'b0;
    step(2);
    finish_count_in = 8'h01; meas_result_condition = 8'h01;
    step(1);
    finish_count_in = '0; meas_result_condition = '0;
    step(TO + 2);

    // Restart with empty mask before ch0 finishes
    start_in = 1'b1;
    meas_mask_in = 8'h01;
    step(1);
    start_in = 1'b0;
    step(2);
    start_in = 1'b1;
    meas_mask_in = 8'h00;
    push_round(8'h00, 1'b0, 8'h00, cyc + 2);
    step(1);
    start_in = 1'b0;
    step(2);
    finish_count_in = 8'h01; meas_result_condition = 8'h01;
    step(1);
    finish_count_in = '0; meas_result_condition = '0;
    step(TO + 4);

    // Reset mid-round discards the round
    start_in = 1'b1;
    meas_mask_in = 8'hFF;
    step(1);
    start_in = 1'b0;
    step(1);
    finish_count_in = 8'h01; meas_result_condition = 8'h01;
    step(1);
    finish_count_in = '0; meas_result_condition = '0;
    chk("pre_reset_ch_valid", 64'(ch_valid_out), 64'h01);
    rst = 1'b1;
    #1;
    chk("midround_reset_outputs", 64'({ch_valid_out, ch_result_out, meas_result_out, missing_out,
                                       valid_meas_result_out, timeout_out, busy_out}), 64'd0);
    step(1);
    rst = 1'b0;
    step(TO + 6);
    chk("busy_after_reset", 64'(busy_out), 64'd0);

`ifdef READOUT_RX_EXCITED_COUNT_EN
    cnt_clear_in = 1'b1;
    step(1);
    cnt_clear_in = 1'b0;
    chk("cnt_cleared", 64'(excited_cnt_out), 64'd0);
    mcnt = 0;
    for (int i = 0; i < 5; i++) begin
      finish_count_in = 8'h04; meas_result_condition = 8'h04;
      step(1);
      if (mcnt < 3) mcnt++;
    end
    finish_count_in = '0; meas_result_condition = '0;
    step(1);
    chk("cnt_saturate_ch2", 64'(excited_cnt_out[2*CWB +: CWB]), 64'(mcnt));
    chk("cnt_other_ch", 64'(excited_cnt_out & ~(16'h3 << (2*CWB))), 64'd0);
    finish_count_in = 8'h04; meas_result_condition = 8'h04; cnt_clear_in = 1'b1;
    step(1);
    cnt_clear_in = 1'b0;
    chk("cnt_clear_priority", 64'(excited_cnt_out[2*CWB +: CWB]), 64'd0);
    step(1);
    finish_count_in = '0; meas_result_condition = '0;
    chk("cnt_inc_after_clear", 64'(excited_cnt_out[2*CWB +: CWB]), 64'd1);
    step(2);
`endif

    step(3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_round: got no valid, expected result 0x%0h at cycle %0d", e.res, e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/readout_rx_state_decision_output_multi.md
Name: readout_rx_state_decision_output_multi

Overview:
- Multi-qubit successor to the single-channel state-decision output stage in the readout RX chain.
- Takes NUM_QUBIT per-channel integration-finish pulses and threshold-comparison conditions, and registers each channel's decision.
- Gathers the decisions of one measurement round, selected by a qubit mask, into a packed result word with a single valid pulse.
- A timeout guarantees the round always completes; the packed word feeds the measurement-result return path to the controller.

Parameters:
- NUM_QUBIT, 8, number of readout channels (1..64).
- TIMEOUT_CYCLES, 1024, COLLECT cycles before a round is force-closed; 0 disables the timeout.
- CNT_WIDTH, 16, width of per-channel excited-count registers (optional feature only).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  pulse: open a new round, captures meas_mask_in.
- meas_mask_in  in  NUM_QUBIT  channels participating in the round.
- finish_count_in  in  NUM_QUBIT  per-channel integration-finished pulse.
- meas_result_condition  in  NUM_QUBIT  per-channel decision (1 = excited), qualified by finish_count_in.
- ch_valid_out  out  NUM_QUBIT  registered copy of finish_count_in.
- ch_result_out  out  NUM_QUBIT  per-channel decision, 0 when ch_valid_out is 0.
- valid_meas_result_out  out  1  one-cycle pulse: round result available.
- meas_result_out  out  NUM_QUBIT  packed round result, 0 when valid is 0.
- timeout_out  out  1  with valid: round closed by timeout.
- missing_out  out  NUM_QUBIT  with valid: masked channels that never finished.
- busy_out  out  1  high while in COLLECT.

Behaviour:
- Reset (async): all outputs, result/done/mask registers, counter and state go to 0/IDLE.
- Per-channel path runs every cycle regardless of state or mask, with 1-cycle latency:
  - ch_valid_out[i] <= finish_count_in[i].
  - ch_result_out[i] <= finish_count_in[i] & meas_result_condition[i].
- FSM states: IDLE, COLLECT.
- IDLE, start_in=1: mask_r <= meas_mask_in; done_r, res_r and counter <= 0; go to COLLECT. Finishes in that same cycle are not recorded into the round.
- COLLECT, each cycle:
  - done_nxt = done_r | (finish_count_in & mask_r & ~done_r).
  - res_r[i] is captured only on the first finish of a masked channel (first wins); later finishes for that channel are ignored.
  - Finishes on unmasked channels are ignored for the round.
- Completion:
  - If done_nxt == mask_r, then at that edge: valid <= 1, meas_result_out <= updated res, timeout_out <= 0, missing_out <= 0; go to IDLE.
  - Latency: the last finish at cycle T gives valid in cycle T+1.
- Timeout (TIMEOUT_CYCLES > 0):
  - counter increments once per COLLECT cycle.
  - If counter == TIMEOUT_CYCLES-1 and done_nxt != mask_r: valid <= 1, timeout_out <= 1, missing_out <= mask_r & ~done_nxt, meas_result_out <= updated res (missing bits 0); go to IDLE.
  - A finish in the expiry cycle counts before the timeout check.
- Empty mask: a round with mask 0 completes at the first COLLECT edge, giving valid 2 cycles after start_in with result 0.
- start_in while in COLLECT aborts the current round: no output, the new mask is loaded, done/res/counter are cleared, and the FSM stays in COLLECT.
- valid_meas_result_out, timeout_out and missing_out are one-cycle pulses; meas_result_out is 0 outside a valid cycle.
- rst mid-round discards the round; no valid is emitted.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Optional Feature:
- Macro: READOUT_RX_EXCITED_COUNT_EN.
- With the macro defined:
  - Adds output excited_cnt_out (NUM_QUBIT*CNT_WIDTH) and input cnt_clear_in (1).
  - Channel i's count increments on every ch_result_out-qualifying event (finish & condition), independent of mask.
  - Each count saturates at all-ones.
  - cnt_clear_in zeroes all counts and takes priority over an increment in the same cycle.
  - rst zeroes all counts.
- Without the macro: these ports and registers do not exist.

Test Plan:
- Reset mid-round: start mask=8'hFF, rst at cycle 3 -> all outputs 0, busy_out=0, no valid ever emitted.
- Full round: start mask=8'h0F; finishes ch0..ch3 at cycles 2,5,5,9 with conditions 1,0,1,1 -> at cycle 10, valid=1, meas_result_out=8'h0D, timeout_out=0; ch_valid_out pulses one cycle after each finish.
- Duplicates and unmasked channels: mask=8'h03; ch0 finishes with cond 1, then again with cond 0; ch5 finishes with cond 1; ch1 finishes with cond 0 -> meas_result_out=8'h01; ch_result_out[5] still pulses 1.
- Timeout: TIMEOUT_CYCLES=16, mask=8'h07, only ch0 finishes (cond 1) -> valid on the 16th COLLECT edge with timeout_out=1, missing_out=8'h06, meas_result_out=8'h01.
- Restart and empty mask: start mask=8'h01, restart with mask=8'h00 before ch0 finishes -> single valid 2 cycles after the second start, result 0; the first round never reports.
- Optional counter (macro defined, CNT_WIDTH=2): 5 excited finishes on ch2 -> excited count 3 (saturated); cnt_clear_in concurrent with a finish -> count 0.
